mem_access_unit: RTL

- MEM-stage load/store engine, sitting between MEM_reg (fed from the EX stage result) and WB_reg.
- Takes one decoded memory op at a time: effective address from the EX stage, store data from rs2, and funct3.
- Performs one single-beat 64-bit AXI read or write on the data-side bus ports.
- Stalls the pipeline while the op is in flight, then returns the sign- or zero-extended load value to WB.

---
 rtl/mem_access_unit.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: one single-beat 64-bit AXI read or write per op,
// stalling the pipeline until the response returns. len/size/burst/wlast are tied off by the top.
module mem_access_unit #(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int TXN_ID     = 1
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  req_valid,
    input  logic                  req_load,
    input  logic                  req_store,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [63:0]           req_wdata,

    output logic                  busy,
    output logic                  done,
    output logic [63:0]           load_data,
    output logic                  err,

    output logic [ID_WIDTH-1:0]   m_arid,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic                  m_arvalid,
    input  logic                  m_arready,

    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rvalid,
    output logic                  m_rready,

    output logic [ID_WIDTH-1:0]   m_awid,
    output logic [ADDR_WIDTH-1:0] m_awaddr,
    output logic                  m_awvalid,
    input  logic                  m_awready,

    output logic [DATA_WIDTH-1:0] m_wdata,
    output logic [7:0]            m_wstrb,
    output logic                  m_wvalid,
    input  logic                  m_wready,

    input  logic [1:0]            m_bresp,
    input  logic                  m_bvalid,
    output logic                  m_bready
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD_A = 3'd1;
    localparam logic [2:0] S_RD_D = 3'd2;
    localparam logic [2:0] S_WR_A = 3'd3;
    localparam logic [2:0] S_WR_B = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic [2:0]            r_state;
    logic [2:0]            w_next_state;

    logic                  r_is_load;
    logic [2:0]            r_funct3;
    logic [2:0]            r_offset;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [7:0]            r_wstrb;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_resp;
    logic                  r_aw_pend;
    logic                  r_w_pend;

    logic                  w_op;
    logic                  w_is_load;
    logic                  w_f3_legal;
    logic                  w_misaligned;
    logic                  w_legal;
    logic                  w_start;
    logic [2:0]            w_offset;
    logic [2:0]            w_align_mask;
    logic [7:0]            w_size_strb;
    logic                  w_aw_ok;
    logic                  w_w_ok;
    logic [63:0]           w_raw;
    logic [63:0]           w_ext;

    // Request decode; a request with both load and store set is treated as a load.
    assign w_op      = req_valid & (req_load | req_store);
    assign w_is_load = req_load;
    assign w_offset  = req_addr[2:0];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_align_mask = 3'd0;
        w_size_strb  = 8'h01;
        case (req_funct3[1:0])
            2'd0: begin w_align_mask = 3'd0; w_size_strb = 8'h01; end
            2'd1: begin w_align_mask = 3'd1; w_size_strb = 8'h03; end
            2'd2: begin w_align_mask = 3'd3; w_size_strb = 8'h0F; end
            default: begin w_align_mask = 3'd7; w_size_strb = 8'hFF; end
        endcase
    end

    assign w_f3_legal   = w_is_load ? (req_funct3 != 3'd7) : ~req_funct3[2];
    assign w_misaligned = |(w_offset & w_align_mask);
    assign w_legal      = w_f3_legal & ~w_misaligned;
    assign w_start      = (r_state == S_IDLE) & w_op & w_legal;

    assign w_aw_ok = ~r_aw_pend | m_awready;
    assign w_w_ok  = ~r_w_pend  | m_wready;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (w_op & w_legal) w_next_state = w_is_load ? S_RD_A : S_WR_A;
            S_RD_A: if (m_arready) w_next_state = S_RD_D;
            S_RD_D: if (m_rvalid) w_next_state = S_DONE;
            S_WR_A: if (w_aw_ok & w_w_ok) w_next_state = S_WR_B;
            S_WR_B: if (m_bvalid) w_next_state = S_DONE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_is_load <= 1'b0;
            r_funct3  <= 3'd0;
            r_offset  <= 3'd0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= 8'h00;
            r_rdata   <= '0;
            r_resp    <= 2'd0;
            r_aw_pend <= 1'b0;
            r_w_pend  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_start) begin
                r_is_load <= w_is_load;
                r_funct3  <= req_funct3;
                r_offset  <= w_offset;
                r_addr    <= {req_addr[ADDR_WIDTH-1:3], 3'b000};
                r_aw_pend <= ~w_is_load;
                r_w_pend  <= ~w_is_load;
                r_wdata   <= w_is_load ? '0 : (req_wdata << {w_offset, 3'b000});
                r_wstrb   <= w_is_load ? 8'h00 : (w_size_strb << w_offset);
            end
            // Each write channel drops its valid independently after its own handshake.
            if (m_awvalid & m_awready) r_aw_pend <= 1'b0;
            if (m_wvalid & m_wready)   r_w_pend  <= 1'b0;
            if (m_rvalid & m_rready) begin
                r_rdata <= m_rdata;
                r_resp  <= m_rresp;
            end
            if (m_bvalid & m_bready) r_resp <= m_bresp;
        end
    end

    assign w_raw = r_rdata >> {r_offset, 3'b000};

    always_comb begin
        w_ext = 64'd0;
        case (r_funct3)
            3'd0: w_ext = {{56{w_raw[7]}},  w_raw[7:0]};
            3'd1: w_ext = {{48{w_raw[15]}}, w_raw[15:0]};
            3'd2: w_ext = {{32{w_raw[31]}}, w_raw[31:0]};
            3'd3: w_ext = w_raw;
            3'd4: w_ext = {56'd0, w_raw[7:0]};
            3'd5: w_ext = {48'd0, w_raw[15:0]};
            3'd6: w_ext = {32'd0, w_raw[31:0]};
            default: w_ext = 64'd0;
        endcase
    end

    // Illegal or misaligned requests complete in the cycle they are seen, with no bus traffic.
    assign busy      = w_op & w_legal & (r_state != S_DONE);
    assign done      = (r_state == S_DONE) | ((r_state == S_IDLE) & w_op & ~w_legal);
    assign err       = (r_state == S_DONE) ? (r_resp != 2'd0)
                                           : ((r_state == S_IDLE) & w_op & ~w_legal);
    assign load_data = ((r_state == S_DONE) & r_is_load) ? w_ext : 64'd0;

    assign m_arid    = ID_WIDTH'(TXN_ID);
    assign m_awid    = ID_WIDTH'(TXN_ID);
    assign m_araddr  = r_addr;
    assign m_awaddr  = r_addr;
    assign m_arvalid = (r_state == S_RD_A);
    assign m_rready  = (r_state == S_RD_D);
    assign m_awvalid = (r_state == S_WR_A) & r_aw_pend;
    assign m_wvalid  = (r_state == S_WR_A) & r_w_pend;
    assign m_wdata   = r_wdata;
    assign m_wstrb   = r_wstrb;
    assign m_bready  = (r_state == S_WR_B);

endmodule
